slink_generic_fc_replay_mc: RTL
===============================

Name: slink_generic_fc_replay_mc

Overview:
Single-clock, multi-channel successor to the app-to-link flow-control replay buffer. Each of NUM_CH application channels owns a DEPTH-entry circular buffer. Entries stay held until the link acknowledges them and can be re-sent after a revert. A round-robin arbiter presents one channel at a time to the link layer, with range-checked ack/revert and error flags.

Parameters:
NUM_CH, 4, number of independent channels (>=2)
DATA_WIDTH, 32, payload width per entry
DEPTH, 8, entries per channel; power of 2, 2..128
ADDR_WIDTH, $clog2(DEPTH), entry index width; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit)
CH_WIDTH, $clog2(NUM_CH), channel index width

Ports:
clk  in  1  clock (all logic on posedge)
reset  in  1  synchronous, active-high reset
enable  in  1  global enable; low = flush all pointers to 0, no traffic
a2l_valid  in  NUM_CH  per-channel write request
a2l_ready  out  NUM_CH  per-channel space available
a2l_data  in  NUM_CH*DATA_WIDTH  channel c data at [c*DATA_WIDTH +: DATA_WIDTH]
empty  out  NUM_CH  channel has nothing unsent (rptr==wptr)
link_ack_update  in  1  ack strobe
link_ack_ch  in  CH_WIDTH  ack channel
link_ack_addr  in  ADDR_WIDTH+1  new ack pointer (first un-acked entry)
link_revert  in  1  revert strobe
link_revert_ch  in  CH_WIDTH  revert channel
link_revert_addr  in  ADDR_WIDTH+1  pointer to resend from
link_valid  out  1  entry presented
link_ch  out  CH_WIDTH  channel of presented entry
link_cur_addr  out  ADDR_WIDTH+1  rptr of presented entry
link_data  out  DATA_WIDTH  presented entry payload
link_advance  in  1  link consumes presented entry
ack_err  out  1  one-cycle pulse: ack rejected
revert_err  out  1  one-cycle pulse: revert rejected

Behaviour:
- Per channel c, three registered pointers: wptr[c], aptr[c], rptr[c], all ADDR_WIDTH+1 bits, wrapping mod 2^(ADDR_WIDTH+1). Storage is a flop array, so reads are combinational with zero latency.
- Reset or !enable: all pointers 0, lock 0, last_grant = NUM_CH-1, ack_err/revert_err 0. Outputs go to a2l_ready 0, empty all 1, link_valid 0, link_ch 0, link_cur_addr 0, link_data 0.
- full[c] = (wptr MSB != aptr MSB) && (low bits equal). a2l_ready[c] = enable && !full[c]. Write on valid&&ready: mem[c][wptr low] <= data; wptr++ (next cycle).
- pending[c] = rptr[c] != wptr[c]; empty[c] = !pending[c].
- Arbiter: if lock=1, sel = cur_ch. Otherwise sel = first pending channel searching from last_grant+1 upward, wrapping. link_valid = enable && pending[sel]. link_ch = sel. link_cur_addr = rptr[sel]. link_data = mem[sel][rptr low]. link_ch/addr/data are 0 when link_valid=0.
- Stability rule: link_valid && !link_advance sets lock=1 and cur_ch=sel. Presented channel, addr and data then hold until advance or a revert on cur_ch.
- link_advance && link_valid: rptr[sel]++, last_grant <= sel, lock <= 0. link_advance with link_valid=0 is ignored.
- Distance d_c(x) = (x - aptr[c]) mod 2^(ADDR_WIDTH+1). All checks use pre-cycle register values.
- Ack accepted if d(ack_addr) <= d(rptr[c]): aptr[c] <= ack_addr. Freed space is visible on a2l_ready the next cycle. Otherwise ignored and ack_err pulses next cycle.
- Revert accepted if d(revert_addr) <= d(rptr[c]): rptr[c] <= revert_addr, and lock clears if revert_ch == cur_ch. Otherwise ignored and revert_err pulses.
- Revert beats advance when both hit the same channel; the advance is discarded and last_grant is unchanged.
- Accepted ack and revert on the same channel in the same cycle: aptr <= ack_addr. rptr <= revert_addr, unless d(ack_addr) > d(revert_addr), in which case rptr <= ack_addr.
- Write and ack on the same channel in the same cycle: both apply. full uses pre-cycle aptr.
- Ack/revert on a channel other than sel: independent, applied in parallel with advance.
- Wrap-around: DEPTH entries fill the channel. Pointer MSB toggles each pass; full/empty/distance remain correct across wrap.

Test Plan:
- Reset, enable=1, write ch0 0xA0..0xA7 (8 words) -> a2l_ready[0]=0 after 8th; link presents ch0 addr 0..7 with data 0xA0..0xA7; ack 8 -> a2l_ready[0]=1 next cycle.
- Ch0,ch1,ch3 each hold 2 entries, advance held 1 -> link_ch order 0,1,3,0,1,3; ch2 never granted.
- Present ch1 addr 2, link_advance=0 for 5 cycles while ch2 writes -> link_ch/addr/data frozen at ch1/2; after advance, next grant is ch2.
- Ch0 sends addr 0..5, revert ch0 addr 3 in same cycle as advance -> rptr[0]=3, replays data of addr 3,4,5; revert addr 7 (beyond rptr) -> revert_err pulse, rptr unchanged.
- Ack ch0 addr 9 with aptr=0, rptr=4 -> ack_err pulse, aptr stays 0; cycle 20 entries through ch0 -> correct data across pointer wrap (addr 15 -> 0).
- Mid-traffic reset=1 for one cycle (or enable=0) -> all pointers 0, link_valid 0, empty=all 1, a2l_ready 0 during reset and 1 after.

Source files
------------

// File: rtl/slink_generic_fc_replay_mc.sv
// slink_generic_fc_replay_mc: multi-channel replay buffer with round-robin link arbitration and range-checked ack/revert
module slink_generic_fc_replay_mc #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int CH_WIDTH   = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            a2l_valid,
   output logic [NUM_CH-1:0]            a2l_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] a2l_data,
   output logic [NUM_CH-1:0]            empty,
   input  logic                         link_ack_update,
   input  logic [CH_WIDTH-1:0]          link_ack_ch,
   input  logic [ADDR_WIDTH:0]          link_ack_addr,
   input  logic                         link_revert,
   input  logic [CH_WIDTH-1:0]          link_revert_ch,
   input  logic [ADDR_WIDTH:0]          link_revert_addr,
   output logic                         link_valid,
   output logic [CH_WIDTH-1:0]          link_ch,
   output logic [ADDR_WIDTH:0]          link_cur_addr,
   output logic [DATA_WIDTH-1:0]        link_data,
   input  logic                         link_advance,
   output logic                         ack_err,
   output logic                         revert_err
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]         wptr_q [NUM_CH];
   logic [PW-1:0]         wptr_d [NUM_CH];
   logic [PW-1:0]         aptr_q [NUM_CH];
   logic [PW-1:0]         aptr_d [NUM_CH];
   logic [PW-1:0]         rptr_q [NUM_CH];
   logic [PW-1:0]         rptr_d [NUM_CH];
   logic [DATA_WIDTH-1:0] mem_q  [NUM_CH][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d  [NUM_CH][DEPTH];
   logic                  lock_q, lock_d;
   logic [CH_WIDTH-1:0]   cur_ch_q, cur_ch_d;
   logic [CH_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic                  ack_err_q, ack_err_d;
   logic                  revert_err_q, revert_err_d;

   logic                  act;
   logic [NUM_CH-1:0]     pending, full, we, ack_ok, rev_ok;
   logic [PW-1:0]         d_r   [NUM_CH];
   logic [PW-1:0]         d_ack [NUM_CH];
   logic [PW-1:0]         d_rev [NUM_CH];
   logic [CH_WIDTH-1:0]   sel;
   logic                  found, rev_sel, adv_fire;

   // Distances are measured from the ack pointer so they stay correct across pointer wrap.
   always_comb begin
      act = enable && !reset;
      for (int c = 0; c < NUM_CH; c++) begin
         pending[c] = rptr_q[c] != wptr_q[c];
         full[c]    = (wptr_q[c] - aptr_q[c]) == PW'(DEPTH);
         d_r[c]     = rptr_q[c] - aptr_q[c];
         d_ack[c]   = link_ack_addr - aptr_q[c];
         d_rev[c]   = link_revert_addr - aptr_q[c];
         ack_ok[c]  = link_ack_update && (link_ack_ch == CH_WIDTH'(c)) && (d_ack[c] <= d_r[c]);
         rev_ok[c]  = link_revert && (link_revert_ch == CH_WIDTH'(c)) && (d_rev[c] <= d_r[c]);
      end
   end

   always_comb begin
      sel   = cur_ch_q;
      found = lock_q;
      for (int i = 1; i <= NUM_CH; i++) begin
         if (!found && pending[CH_WIDTH'((int'(last_grant_q) + i) % NUM_CH)]) begin
            found = 1'b1;
            sel   = CH_WIDTH'((int'(last_grant_q) + i) % NUM_CH);
         end
      end
   end

   always_comb begin
      a2l_ready     = act ? ~full : '0;
      empty         = act ? ~pending : '1;
      link_valid    = act && pending[sel];
      link_ch       = link_valid ? sel : '0;
      link_cur_addr = link_valid ? rptr_q[sel] : '0;
      link_data     = link_valid ? mem_q[sel][rptr_q[sel][ADDR_WIDTH-1:0]] : '0;
      ack_err       = ack_err_q;
      revert_err    = revert_err_q;
      rev_sel       = rev_ok[sel];
      adv_fire      = link_valid && link_advance && !rev_sel;
   end

   always_comb begin
      mem_d = mem_q;
      for (int c = 0; c < NUM_CH; c++) begin
         we[c]     = a2l_valid[c] && a2l_ready[c];
         if (we[c])
            mem_d[c][wptr_q[c][ADDR_WIDTH-1:0]] = a2l_data[c*DATA_WIDTH +: DATA_WIDTH];
         wptr_d[c] = wptr_q[c] + PW'(we[c]);
         aptr_d[c] = ack_ok[c] ? link_ack_addr : aptr_q[c];
         rptr_d[c] = rev_ok[c] ? ((ack_ok[c] && d_ack[c] > d_rev[c]) ? link_ack_addr : link_revert_addr)
                   : (adv_fire && sel == CH_WIDTH'(c)) ? rptr_q[c] + PW'(1) : rptr_q[c];
      end
      lock_d       = link_valid && !link_advance && !rev_sel;
      cur_ch_d     = link_valid ? sel : cur_ch_q;
      last_grant_d = adv_fire ? sel : last_grant_q;
      ack_err_d    = act && link_ack_update && !(|ack_ok);
      revert_err_d = act && link_revert && !(|rev_ok);
   end

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         wptr_q       <= '{default: '0};
         aptr_q       <= '{default: '0};
         rptr_q       <= '{default: '0};
         lock_q       <= 1'b0;
         cur_ch_q     <= '0;
         last_grant_q <= CH_WIDTH'(NUM_CH - 1);
         ack_err_q    <= 1'b0;
         revert_err_q <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         aptr_q       <= aptr_d;
         rptr_q       <= rptr_d;
         lock_q       <= lock_d;
         cur_ch_q     <= cur_ch_d;
         last_grant_q <= last_grant_d;
         ack_err_q    <= ack_err_d;
         revert_err_q <= revert_err_d;
      end
      mem_q <= mem_d;
   end
endmodule
